// File: rtl/id_stage.sv
// Instruction decode stage: decodes one RV32I-subset instruction per accepted
// beat and buffers the decoded bundle in a 2-entry FIFO towards execute.
// Optional feature macro: ID_STAGE_RV32M_EN. When defined, mul/mulh/div/rem
// are decoded; otherwise those encodings are flagged illegal.
module id_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_pcsel,
  output logic               out_alusrc1,
  output logic               out_alusrc2,
  output logic               out_regwe,
  output logic               out_memwe,
  output logic [1:0]         out_wbsel,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_pc,
  output logic               out_illegal
);

  // illegal, pcsel, alusrc1, alusrc2, regwe, memwe, wbsel, aluop, imm, pc
  localparam int unsigned BundleW = 6 + 2 + ALUOP_W + 2 * XLEN;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_op = in_inst[6:0];
  assign w_f3 = in_inst[14:12];
  assign w_f7 = in_inst[31:25];

  // Immediates are built at 32 bits, then sign-extended to XLEN by the casts.
  logic signed [31:0] w_imm_i32, w_imm_s32, w_imm_b32, w_imm_u32, w_imm_j32;

  assign w_imm_i32 = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                      in_inst[11:8], 1'b0};
  assign w_imm_u32 = {in_inst[31:12], 12'b0};
  assign w_imm_j32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                      in_inst[30:21], 1'b0};

  logic               w_dec_illegal;
  logic               w_dec_pcsel;
  logic               w_dec_alusrc1;
  logic               w_dec_alusrc2;
  logic               w_dec_regwe;
  logic               w_dec_memwe;
  logic [1:0]         w_dec_wbsel;
  logic [ALUOP_W-1:0] w_dec_aluop;
  logic [XLEN-1:0]    w_dec_imm;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    w_dec_illegal = 1'b0;
    w_dec_pcsel   = 1'b0;
    w_dec_alusrc1 = 1'b0;
    w_dec_alusrc2 = 1'b1;
    w_dec_regwe   = 1'b0;
    w_dec_memwe   = 1'b0;
    w_dec_wbsel   = 2'b00;
    w_dec_aluop   = '0;
    w_dec_imm     = '0;
    unique case (w_op)
      7'b0110111: begin // lui
        w_dec_aluop = ALUOP_W'(5'b10110);
        w_dec_imm   = XLEN'(w_imm_u32);
        w_dec_regwe = 1'b1;
      end
      7'b0010111: begin // auipc
        w_dec_aluop   = ALUOP_W'(5'b10111);
        w_dec_imm     = XLEN'(w_imm_u32);
        w_dec_alusrc1 = 1'b1;
        w_dec_regwe   = 1'b1;
      end
      7'b1101111: begin // jal
        w_dec_aluop   = ALUOP_W'(5'b10000);
        w_dec_imm     = XLEN'(w_imm_j32);
        w_dec_pcsel   = 1'b1;
        w_dec_alusrc1 = 1'b1;
        w_dec_regwe   = 1'b1;
        w_dec_wbsel   = 2'b10;
      end
      7'b1100111: begin // jalr
        w_dec_aluop   = ALUOP_W'(5'b10100);
        w_dec_imm     = XLEN'(w_imm_i32);
        w_dec_pcsel   = 1'b1;
        w_dec_regwe   = 1'b1;
        w_dec_wbsel   = 2'b10;
        w_dec_illegal = (w_f3 != 3'b000);
      end
      7'b1100011: begin // beq / bne / blt
        w_dec_imm     = XLEN'(w_imm_b32);
        w_dec_pcsel   = 1'b1;
        w_dec_alusrc1 = 1'b1;
        unique case (w_f3)
          3'b000:  w_dec_aluop = ALUOP_W'(5'b10001);
          3'b001:  w_dec_aluop = ALUOP_W'(5'b10010);
          3'b100:  w_dec_aluop = ALUOP_W'(5'b10011);
          default: w_dec_illegal = 1'b1;
        endcase
      end
      7'b0000011: begin // lw
        w_dec_aluop   = ALUOP_W'(5'b10100);
        w_dec_imm     = XLEN'(w_imm_i32);
        w_dec_regwe   = 1'b1;
        w_dec_wbsel   = 2'b01;
        w_dec_illegal = (w_f3 != 3'b010);
      end
      7'b0100011: begin // sw
        w_dec_aluop   = ALUOP_W'(5'b10101);
        w_dec_imm     = XLEN'(w_imm_s32);
        w_dec_memwe   = 1'b1;
        w_dec_illegal = (w_f3 != 3'b010);
      end
      7'b0010011: begin // addi
        w_dec_aluop   = ALUOP_W'(5'b01100);
        w_dec_imm     = XLEN'(w_imm_i32);
        w_dec_regwe   = 1'b1;
        w_dec_illegal = (w_f3 != 3'b000);
      end
      7'b0110011: begin // register-register ALU ops, imm stays 0
        w_dec_alusrc2 = 1'b0;
        w_dec_regwe   = 1'b1;
        unique case ({w_f7, w_f3})
          {7'b0000000, 3'b000}: w_dec_aluop = ALUOP_W'(5'b01101); // add
          {7'b0100000, 3'b000}: w_dec_aluop = ALUOP_W'(5'b01110); // sub
          {7'b0000000, 3'b001}: w_dec_aluop = ALUOP_W'(5'b01000); // sll
          {7'b0000000, 3'b101}: w_dec_aluop = ALUOP_W'(5'b01001); // srl
          {7'b0100000, 3'b101}: w_dec_aluop = ALUOP_W'(5'b01011); // sra
          {7'b0000000, 3'b100}: w_dec_aluop = ALUOP_W'(5'b00110); // xor
          {7'b0000000, 3'b110}: w_dec_aluop = ALUOP_W'(5'b00101); // or
          {7'b0000000, 3'b111}: w_dec_aluop = ALUOP_W'(5'b00100); // and
`ifdef ID_STAGE_RV32M_EN
          {7'b0000001, 3'b000}: w_dec_aluop = ALUOP_W'(5'b11000); // mul
          {7'b0000001, 3'b001}: w_dec_aluop = ALUOP_W'(5'b11001); // mulh
          {7'b0000001, 3'b100}: w_dec_aluop = ALUOP_W'(5'b11010); // div
          {7'b0000001, 3'b110}: w_dec_aluop = ALUOP_W'(5'b11011); // rem
`endif
          default: w_dec_illegal = 1'b1;
        endcase
      end
      default: w_dec_illegal = 1'b1;
    endcase
    // An illegal word must never write state or steer the PC downstream.
    if (w_dec_illegal) begin
      w_dec_pcsel   = 1'b0;
      w_dec_alusrc1 = 1'b0;
      w_dec_alusrc2 = 1'b0;
      w_dec_regwe   = 1'b0;
      w_dec_memwe   = 1'b0;
      w_dec_wbsel   = 2'b00;
      w_dec_aluop   = '0;
      w_dec_imm     = '0;
    end
  end

  logic [BundleW-1:0] w_dec_bundle;

  assign w_dec_bundle = {w_dec_illegal, w_dec_pcsel, w_dec_alusrc1, w_dec_alusrc2, w_dec_regwe,
                         w_dec_memwe, w_dec_wbsel, w_dec_aluop, w_dec_imm, in_pc};

  logic [BundleW-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_push;
  logic               w_pop;

  // Ready depends only on the occupancy register, never on out_ready.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // FIFO storage, pointers and occupancy; flush empties and drops any input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec_bundle;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  logic [BundleW-1:0] w_out_bundle;

  // Head entry is presented only while valid; otherwise every field reads 0.
  always_comb begin
    w_out_bundle = '0;
    if (out_valid) begin
      w_out_bundle = r_mem[r_rd_ptr];
    end
  end

  assign {out_illegal, out_pcsel, out_alusrc1, out_alusrc2, out_regwe, out_memwe, out_wbsel,
          out_aluop, out_imm, out_pc} = w_out_bundle;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage (XLEN=64): a mnemonic-table decode model and
// a queue-based FIFO model checked every cycle, plus directed literal checks.
module tb_id_stage;

  localparam int unsigned XLEN = 64;

  typedef struct packed {
    logic        illegal;
    logic        pcsel;
    logic        alusrc1;
    logic        alusrc2;
    logic        regwe;
    logic        memwe;
    logic [1:0]  wbsel;
    logic [4:0]  aluop;
    logic [63:0] imm;
    logic [63:0] pc;
  } bundle_t;

  localparam bit N = 1'b0;
  localparam bit Y = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_pcsel, out_alusrc1, out_alusrc2, out_regwe, out_memwe, out_illegal;
  logic [1:0]  out_wbsel;
  logic [4:0]  out_aluop;
  logic [63:0] out_imm, out_pc;

  int total = 0;
  int bad = 0;

  bundle_t model_q[$];
  bundle_t dut_b;

  id_stage #(.XLEN(XLEN), .ALUOP_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pcsel(out_pcsel), .out_alusrc1(out_alusrc1), .out_alusrc2(out_alusrc2),
    .out_regwe(out_regwe), .out_memwe(out_memwe), .out_wbsel(out_wbsel),
    .out_aluop(out_aluop), .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    dut_b = {out_illegal, out_pcsel, out_alusrc1, out_alusrc2, out_regwe, out_memwe,
             out_wbsel, out_aluop, out_imm, out_pc};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input bundle_t act, input bundle_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is(input logic [31:0] inst, input logic [31:0] mask,
                            input logic [31:0] match);
    return (inst & mask) == match;
  endfunction

  function automatic bundle_t mk(input logic [4:0] op, input logic [63:0] imm,
                                 input bit pcsel, input bit s1, input bit s2,
                                 input bit we, input bit mwe, input logic [1:0] wb);
    bundle_t b;
    b = '0;
    b.aluop = op;
    b.imm = imm;
    b.pcsel = pcsel;
    b.alusrc1 = s1;
    b.alusrc2 = s2;
    b.regwe = we;
    b.memwe = mwe;
    b.wbsel = wb;
    return b;
  endfunction

  // Reference decode: mnemonic table lookup, immediates by signed arithmetic.
  function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [63:0] pc);
    bundle_t b;
    longint  s;
    longint  imm_i, imm_s, imm_b, imm_u, imm_j;
    s = longint'($signed(inst));
    imm_i = s >>> 20;
    imm_s = ((s >>> 25) <<< 5) | longint'(inst[11:7]);
    imm_b = ((s >>> 31) <<< 12) | (longint'(inst[7]) <<< 11) | (longint'(inst[30:25]) <<< 5)
            | (longint'(inst[11:8]) <<< 1);
    imm_u = (s >>> 12) <<< 12;
    imm_j = ((s >>> 31) <<< 20) | (longint'(inst[19:12]) <<< 12) | (longint'(inst[20]) <<< 11)
            | (longint'(inst[30:21]) <<< 1);
    b = '0;
    b.illegal = 1'b0;
    if      (is(inst, 32'h7F, 32'h37))   b = mk(5'h16, imm_u, N, N, Y, Y, N, 2'b00); // lui
    else if (is(inst, 32'h7F, 32'h17))   b = mk(5'h17, imm_u, N, Y, Y, Y, N, 2'b00); // auipc
    else if (is(inst, 32'h7F, 32'h6F))   b = mk(5'h10, imm_j, Y, Y, Y, Y, N, 2'b10); // jal
    else if (is(inst, 32'h707F, 32'h67)) b = mk(5'h14, imm_i, Y, N, Y, Y, N, 2'b10); // jalr
    else if (is(inst, 32'h707F, 32'h63)) b = mk(5'h11, imm_b, Y, Y, Y, N, N, 2'b00); // beq
    else if (is(inst, 32'h707F, 32'h1063)) b = mk(5'h12, imm_b, Y, Y, Y, N, N, 2'b00); // bne
    else if (is(inst, 32'h707F, 32'h4063)) b = mk(5'h13, imm_b, Y, Y, Y, N, N, 2'b00); // blt
    else if (is(inst, 32'h707F, 32'h2003)) b = mk(5'h14, imm_i, N, N, Y, Y, N, 2'b01); // lw
    else if (is(inst, 32'h707F, 32'h2023)) b = mk(5'h15, imm_s, N, N, Y, N, Y, 2'b00); // sw
    else if (is(inst, 32'h707F, 32'h13))   b = mk(5'h0C, imm_i, N, N, Y, Y, N, 2'b00); // addi
    else if (is(inst, 32'hFE00707F, 32'h33))       b = mk(5'h0D, 0, N, N, N, Y, N, 2'b00);
    else if (is(inst, 32'hFE00707F, 32'h40000033)) b = mk(5'h0E, 0, N, N, N, Y, N, 2'b00);
    else if (is(inst, 32'hFE00707F, 32'h1033))     b = mk(5'h08, 0, N, N, N, Y, N, 2'b00);
    else if (is(inst, 32'hFE00707F, 32'h5033))     b = mk(5'h09, 0, N, N, N, Y, N, 2'b00);
    else if (is(inst, 32'hFE00707F, 32'h40005033)) b = mk(5'h0B, 0, N, N, N, Y, N, 2'b00);
    else if (is(inst, 32'hFE00707F, 32'h4033))     b = mk(5'h06, 0, N, N, N, Y, N, 2'b00);
    else if (is(inst, 32'hFE00707F, 32'h6033))     b = mk(5'h05, 0, N, N, N, Y, N, 2'b00);
    else if (is(inst, 32'hFE00707F, 32'h7033))     b = mk(5'h04, 0, N, N, N, Y, N, 2'b00);
`ifdef ID_STAGE_RV32M_EN
    else if (is(inst, 32'hFE00707F, 32'h02000033)) b = mk(5'h18, 0, N, N, N, Y, N, 2'b00);
    else if (is(inst, 32'hFE00707F, 32'h02001033)) b = mk(5'h19, 0, N, N, N, Y, N, 2'b00);
    else if (is(inst, 32'hFE00707F, 32'h02004033)) b = mk(5'h1A, 0, N, N, N, Y, N, 2'b00);
    else if (is(inst, 32'hFE00707F, 32'h02006033)) b = mk(5'h1B, 0, N, N, N, Y, N, 2'b00);
`endif
    else b.illegal = 1'b1;
    b.pc = pc;
    return b;
  endfunction

  // Random instruction biased towards decodable encodings.
  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [31:0] mask;
    logic [31:0] match;
    r = $urandom;
    mask = 32'hFE00707F;
    match = 32'h0;
    case ($urandom_range(0, 25))
      0:  begin mask = 32'h7F;   match = 32'h37;   end
      1:  begin mask = 32'h7F;   match = 32'h17;   end
      2:  begin mask = 32'h7F;   match = 32'h6F;   end
      3:  begin mask = 32'h707F; match = 32'h67;   end
      4:  begin mask = 32'h707F; match = 32'h63;   end
      5:  begin mask = 32'h707F; match = 32'h1063; end
      6:  begin mask = 32'h707F; match = 32'h4063; end
      7:  begin mask = 32'h707F; match = 32'h2003; end
      8:  begin mask = 32'h707F; match = 32'h2023; end
      9:  begin mask = 32'h707F; match = 32'h13;   end
      10: match = 32'h33;
      11: match = 32'h40000033;
      12: match = 32'h1033;
      13: match = 32'h5033;
      14: match = 32'h40005033;
      15: match = 32'h4033;
      16: match = 32'h6033;
      17: match = 32'h7033;
      18: match = 32'h02000033;
      19: match = 32'h02001033;
      20: match = 32'h02004033;
      21: match = 32'h02006033;
      default: mask = 32'h0;
    endcase
    return (r & ~mask) | match;
  endfunction

  // FIFO model: occupancy and order tracked as a queue of expected bundles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      case (model_q.size())
        0: if (in_valid) model_q.push_back(ref_decode(in_inst, in_pc));
        1: begin
          if (in_valid) model_q.push_back(ref_decode(in_inst, in_pc));
          if (out_ready) void'(model_q.pop_front());
        end
        default: if (out_ready) void'(model_q.pop_front());
      endcase
    end
  end

  // Per-cycle compare against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
      if (model_q.size() == 0) begin
        chkb("idle_bundle", dut_b, '0);
      end else if (model_q[0].illegal) begin
        chk("illegal_fields",
            {57'(out_pc[55:0]), out_illegal, out_pcsel, out_regwe, out_memwe, out_aluop[2:0]},
            {57'(model_q[0].pc[55:0]), 1'b1, 1'b0, 1'b0, 1'b0, 3'b000});
        chk("illegal_aluop", 64'(out_aluop), 64'h0);
      end else begin
        chkb("bundle", dut_b, model_q[0]);
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                     input bit ordy, input bit fl);
    in_valid = v;
    in_inst = inst;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then release.
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_imm", out_imm, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'h1);

    // addi x1,x0,5
    cyc(Y, 32'h00500093, 64'h100, Y, N);
    chk("addi_valid", 64'(out_valid), 64'h1);
    chk("addi_aluop", 64'(out_aluop), 64'h0C);
    chk("addi_imm", out_imm, 64'h5);
    chk("addi_regwe", 64'(out_regwe), 64'h1);
    chk("addi_alusrc2", 64'(out_alusrc2), 64'h1);
    chk("addi_pc", out_pc, 64'h100);
    chk("model_addi_aluop", 64'(model_q[0].aluop), 64'h0C);
    chk("model_addi_imm", model_q[0].imm, 64'h5);
    cyc(N, 0, 0, Y, N);
    cyc(N, 0, 0, Y, N);

    // add then sub buffered with downstream stalled, then drained in order.
    cyc(Y, 32'h00208033, 64'h104, N, N);
    cyc(Y, 32'h40208033, 64'h108, N, N);
    chk("full_in_ready", 64'(in_ready), 64'h0);
    chk("full_head_add", 64'(out_aluop), 64'h0D);
    cyc(N, 0, 0, Y, N);
    chk("drain_sub", 64'(out_aluop), 64'h0E);
    chk("drain_sub_pc", out_pc, 64'h108);
    cyc(N, 0, 0, Y, N);
    chk("drained_valid", 64'(out_valid), 64'h0);

    // sw and beq immediates at XLEN=64.
    cyc(Y, 32'h0020A223, 64'h200, Y, N);
    chk("sw_memwe", 64'(out_memwe), 64'h1);
    chk("sw_regwe", 64'(out_regwe), 64'h0);
    chk("sw_imm", out_imm, 64'h4);
    chk("sw_aluop", 64'(out_aluop), 64'h15);
    chk("model_sw_imm", model_q[0].imm, 64'h4);
    cyc(Y, 32'hFE000EE3, 64'h204, Y, N);
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_pcsel", 64'(out_pcsel), 64'h1);
    chk("model_beq_imm", model_q[0].imm, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(N, 0, 0, Y, N);

    // mul (feature dependent) and an all-ones word.
    cyc(Y, 32'h022080B3, 64'h300, Y, N);
`ifdef ID_STAGE_RV32M_EN
    chk("mul_aluop", 64'(out_aluop), 64'h18);
    chk("mul_illegal", 64'(out_illegal), 64'h0);
`else
    chk("mul_illegal", 64'(out_illegal), 64'h1);
    chk("mul_regwe", 64'(out_regwe), 64'h0);
`endif
    cyc(Y, 32'hFFFFFFFF, 64'h304, Y, N);
    chk("ones_illegal", 64'(out_illegal), 64'h1);
    chk("ones_aluop", 64'(out_aluop), 64'h0);
    cyc(N, 0, 0, Y, N);

    // Flush with two entries buffered and a same-cycle input.
    cyc(Y, 32'h00208033, 64'h400, N, N);
    cyc(Y, 32'h40208033, 64'h404, N, N);
    chk("preflush_valid", 64'(out_valid), 64'h1);
    cyc(Y, 32'h00500093, 64'h408, Y, Y);
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_in_ready", 64'(in_ready), 64'h1);
    chk("flush_aluop", 64'(out_aluop), 64'h0);
    cyc(N, 0, 0, Y, N);
    chk("postflush_valid", 64'(out_valid), 64'h0);

    // Asynchronous reset mid-stream with two entries buffered.
    cyc(Y, 32'h00208033, 64'h500, N, N);
    cyc(Y, 32'h40208033, 64'h504, N, N);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    chk("async_rst_pc", out_pc, 64'h0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(N, 0, 0, Y, N);
    chk("postrst_valid", 64'(out_valid), 64'h0);
    chk("postrst_in_ready", 64'(in_ready), 64'h1);
    cyc(Y, 32'h00500093, 64'h600, Y, N);
    chk("postrst_addi_aluop", 64'(out_aluop), 64'h0C);
    chk("postrst_addi_pc", out_pc, 64'h600);

    // Randomised traffic checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), rand_inst(), {$urandom, $urandom},
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
    end
    cyc(N, 0, 0, Y, N);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
